// File: rtl/piece_counter_bcd_if.sv
// Sensor/control inputs and BCD display outputs of the conveyor piece counter.
// The master side drives the sensor and controls; the slave side is the counter.
interface piece_counter_bcd_if;
    logic       iSENSOR;
    logic       iENABLE;
    logic       iCLEAR;
    logic [3:0] oD0;
    logic [3:0] oD1;
    logic [3:0] oD2;
    logic [3:0] oD3;
    logic       oPULSE;
    logic       oBATCH_DONE;

    modport master (
        output iSENSOR, iENABLE, iCLEAR,
        input  oD0, oD1, oD2, oD3, oPULSE, oBATCH_DONE
    );

    modport slave (
        input  iSENSOR, iENABLE, iCLEAR,
        output oD0, oD1, oD2, oD3, oPULSE, oBATCH_DONE
    );
endinterface

// File: rtl/piece_counter_bcd.sv
// Debounced conveyor piece counter with a four-digit BCD display count that
// saturates at BATCH_SIZE and raises a sticky batch-done flag.
module piece_counter_bcd #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BATCH_SIZE      = 12
) (
    input logic                iCLK,
    input logic                iRST,
    piece_counter_bcd_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (res[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        bcd_inc = res;
    endfunction

    localparam logic [15:0] BATCH_BCD = to_bcd(BATCH_SIZE);

    logic          s1_q, s2_q;
    logic          filt_q, filt_d;
    logic          filt_dly_q;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [15:0]   count_q, count_d;
    logic          pulse_q, pulse_d;
    logic          done_q, done_d;
    logic          event_s;

    // Two-flop synchroniser for the asynchronous sensor input.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.iSENSOR;
            s2_q <= s1_q;
        end
    end

    // Debounce: filtered level follows s2 only after it has differed long enough.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (s2_q == filt_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == CNT_LAST) begin
            filt_d    = s2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign event_s = filt_q & ~filt_dly_q & bus.iENABLE;

    // Count update; clear wins over a coincident event, and a full batch drops events.
    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        done_d  = done_q;
        if (bus.iCLEAR) begin
            count_d = 16'h0000;
            done_d  = 1'b0;
        end else if (event_s && !done_q) begin
            count_d = bcd_inc(count_q);
            pulse_d = 1'b1;
            done_d  = (bcd_inc(count_q) == BATCH_BCD);
        end else begin
            pulse_d = 1'b0;
        end
    end

    // State registers for the filter, edge detector and display count.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            deb_cnt_q  <= '0;
            count_q    <= 16'h0000;
            pulse_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            deb_cnt_q  <= deb_cnt_d;
            count_q    <= count_d;
            pulse_q    <= pulse_d;
            done_q     <= done_d;
        end
    end

    assign bus.oD0         = count_q[3:0];
    assign bus.oD1         = count_q[7:4];
    assign bus.oD2         = count_q[11:8];
    assign bus.oD3         = count_q[15:12];
    assign bus.oPULSE      = pulse_q;
    assign bus.oBATCH_DONE = done_q;
endmodule
